// File: rtl/glitc_align_pkg.sv
// Shared types and the sample-slice helper for the GLITC per-channel word aligner.
package glitc_align_pkg;

  localparam int unsigned NSAMP     = 4;
  localparam int unsigned SAMP_BITS = 12;
  localparam int unsigned WORD_BITS = NSAMP * SAMP_BITS;

  typedef logic [NSAMP-1:0][SAMP_BITS-1:0] word_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_COUNT,
    S_LOCKED,
    S_FAIL
  } state_t;

  // Aligned sample k = s[k+4-ofs], with s0..s3 from prev and s4..s7 from cur.
  function automatic word_t sample_slice(input word_t prev, input word_t cur,
                                         input logic [1:0] ofs);
    logic [2*NSAMP-1:0][SAMP_BITS-1:0] s;
    logic [2:0]                        idx;
    word_t                             res;
    s = {cur, prev};
    for (int k = 0; k < NSAMP; k++) begin
      idx    = 3'(k + NSAMP) - 3'(ofs);
      res[k] = s[idx];
    end
    return res;
  endfunction

endpackage

// File: rtl/glitc_word_delay.sv
// Programmable whole-word delay: latency 1 for delay 0/1, otherwise delay-1 beyond the input.
module glitc_word_delay
  import glitc_align_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  word_t                    din,
  input  logic [$clog2(DEPTH)-1:0] delay,
  output word_t                    dout
);

  localparam int unsigned DW   = $clog2(DEPTH);
  localparam int unsigned TAPS = (DEPTH > 2) ? DEPTH - 2 : 1;

  word_t          sr [TAPS];
  logic [DW-1:0]  tap_idx;

  always_comb tap_idx = delay - DW'(2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(TAPS); i++) sr[i] <= '0;
      dout <= '0;
    end else begin
      sr[0] <= din;
      for (int i = 1; i < int'(TAPS); i++) sr[i] <= sr[i-1];
      dout <= (delay < DW'(2)) ? din : sr[tap_idx];
    end
  end

endmodule

// File: rtl/glitc_sample_aligner.sv
// GLITC per-channel sample aligner: training search for the sample offset plus word delay.
// Optional mismatch counter while locked: define GLITC_ALIGN_ERRCNT_EN.
module glitc_sample_aligner
  import glitc_align_pkg::*;
#(
  parameter int unsigned MATCH_COUNT = 16,
  parameter int unsigned SETTLE      = 2,
  parameter int unsigned DELAY_DEPTH = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [WORD_BITS-1:0]           din_i,
  input  logic [WORD_BITS-1:0]           pattern_i,
  input  logic                           train_i,
  input  logic [$clog2(DELAY_DEPTH)-1:0] delay_i,
  output logic [WORD_BITS-1:0]           dout_o,
  output logic [1:0]                     offset_o,
  output logic                           busy_o,
  output logic                           locked_o,
  output logic                           fail_o,
  output logic [15:0]                    err_count_o
);

  localparam int unsigned CW  = $clog2(MATCH_COUNT + 1);
  localparam int unsigned SCW = $clog2(SETTLE);

  word_t           cur, prev, aligned, dly_out;
  state_t          state;
  logic [CW-1:0]   match_cnt;
  logic [SCW-1:0]  settle_cnt;

  // Two-word window and the offset-selected slice.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur     <= '0;
      prev    <= '0;
      aligned <= '0;
    end else begin
      prev    <= cur;
      cur     <= din_i;
      aligned <= sample_slice(prev, cur, offset_o);
    end
  end

  glitc_word_delay #(.DEPTH(DELAY_DEPTH)) u_delay (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (aligned),
    .delay (delay_i),
    .dout  (dly_out)
  );

  assign dout_o = dly_out;

  // Search FSM; train_i overrides every state, including the cycle a lock would occur.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      offset_o   <= '0;
      match_cnt  <= '0;
      settle_cnt <= '0;
      busy_o     <= 1'b0;
      locked_o   <= 1'b0;
      fail_o     <= 1'b0;
    end else if (train_i) begin
      state      <= S_SETTLE;
      offset_o   <= '0;
      match_cnt  <= '0;
      settle_cnt <= '0;
      busy_o     <= 1'b1;
      locked_o   <= 1'b0;
      fail_o     <= 1'b0;
    end else begin
      case (state)
        S_SETTLE: begin
          if (settle_cnt == SCW'(SETTLE - 1)) begin
            state      <= S_COUNT;
            settle_cnt <= '0;
          end else begin
            settle_cnt <= settle_cnt + SCW'(1);
          end
        end
        S_COUNT: begin
          if (aligned == pattern_i) begin
            if (match_cnt == CW'(MATCH_COUNT - 1)) begin
              state     <= S_LOCKED;
              match_cnt <= CW'(MATCH_COUNT);
              busy_o    <= 1'b0;
              locked_o  <= 1'b1;
            end else begin
              match_cnt <= match_cnt + CW'(1);
            end
          end else if (offset_o != 2'd3) begin
            state     <= S_SETTLE;
            offset_o  <= offset_o + 2'd1;
            match_cnt <= '0;
          end else begin
            state  <= S_FAIL;
            busy_o <= 1'b0;
            fail_o <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef GLITC_ALIGN_ERRCNT_EN
  // Saturating count of words that disagree with the pattern after lock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count_o <= '0;
    end else if (train_i) begin
      err_count_o <= '0;
    end else if (state == S_LOCKED && aligned != pattern_i && err_count_o != 16'hFFFF) begin
      err_count_o <= err_count_o + 16'd1;
    end
  end
`else
  assign err_count_o = '0;
`endif

endmodule

// File: tb/tb_glitc_sample_aligner.sv
// Directed self-checking bench for glitc_sample_aligner (default parameters).
module tb_glitc_sample_aligner;

  logic        clk;
  logic        rst_n;
  logic [47:0] din, pattern, dout;
  logic        train;
  logic [2:0]  delay;
  logic [1:0]  offset;
  logic        busy, locked, fail;
  logic [15:0] err_count;

  int n_checks;
  int n_errors;
  int first_hit;
  int ph;
  int ofs;

`ifdef GLITC_ALIGN_ERRCNT_EN
  localparam int unsigned EXP_ERR = 3;
`else
  localparam int unsigned EXP_ERR = 0;
`endif

  localparam logic [47:0] P      = 48'h444_333_222_111;
  localparam logic [47:0] MARKER = 48'hABC_123_456_789;

  // Stream word that aligns to P at offset o: W[j] = P[(j+o) mod 4].
  logic [47:0] wrot [4];
  logic [47:0] tw   [6];

  glitc_sample_aligner dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .din_i       (din),
    .pattern_i   (pattern),
    .train_i     (train),
    .delay_i     (delay),
    .dout_o      (dout),
    .offset_o    (offset),
    .busy_o      (busy),
    .locked_o    (locked),
    .fail_o      (fail),
    .err_count_o (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_train();
    train = 1'b1;
    step(1);
    train = 1'b0;
  endtask

  // Steps until locked_o or fail_o rises; returns edge count or -1 if the bound expires.
  task automatic wait_flag(input bit want_fail, input int bound, output int edges);
    edges = -1;
    for (int k = 1; k <= bound; k++) begin
      step(1);
      if ((want_fail ? fail : locked) && edges < 0) begin
        edges = k;
        break;
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    wrot[0] = 48'h444_333_222_111;
    wrot[1] = 48'h111_444_333_222;
    wrot[2] = 48'h222_111_444_333;
    wrot[3] = 48'h333_222_111_444;
    tw[0] = 48'h00A_00B_00C_00D;
    tw[1] = 48'h1A1_1B1_1C1_1D1;
    tw[2] = 48'h2A2_2B2_2C2_2D2;
    tw[3] = 48'h3A3_3B3_3C3_3D3;
    tw[4] = 48'h4A4_4B4_4C4_4D4;
    tw[5] = 48'h5A5_5B5_5C5_5D5;

    rst_n   = 1'b0;
    train   = 1'b0;
    delay   = 3'd0;
    pattern = P;
    din     = '0;

    // Reset with random input words: everything stays at zero.
    for (int i = 0; i < 4; i++) begin
      din = {$urandom(), 16'($urandom())};
      step(1);
    end
    chk("rst_dout",   64'(dout), 64'h0);
    chk("rst_flags",  64'({busy, locked, fail}), 64'h0);
    chk("rst_offset", 64'(offset), 64'h0);
    chk("rst_err",    64'(err_count), 64'h0);

    // Release: IDLE, offset 0, three-cycle pass-through with delay 0.
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      din = tw[i];
      step(1);
      if (i >= 2) chk($sformatf("lat3_w%0d", i - 2), 64'(dout), 64'(tw[i-2]));
    end
    chk("idle_flags",  64'({busy, locked, fail}), 64'h0);
    chk("idle_offset", 64'(offset), 64'h0);

    // Stream rotated by two samples: offsets 0 and 1 fail fast, lock 24 edges after train.
    din = wrot[2];
    pulse_train();
    chk("t2_busy", 64'(busy), 64'h1);
    wait_flag(1'b0, 74, first_hit);
    chk("t2_lock_edge", 64'(first_hit), 64'd24);
    chk("t2_offset", 64'(offset), 64'd2);
    chk("t2_busy_fail", 64'({busy, fail}), 64'h0);

    // Worst-case search: 15 matches then a bad word at every offset; FAIL on edge 72.
    din = wrot[0];
    pulse_train();
    first_hit = -1;
    for (int n = 1; n <= 74; n++) begin
      ph  = n % 18;
      ofs = n / 18;
      din = (ph >= 16 || ofs > 3) ? 48'h0 : wrot[ofs];
      step(1);
      if (n == 40) chk("t3_mid_offset", 64'(offset), 64'd2);
      if (fail && first_hit < 0) first_hit = n;
    end
    chk("t3_fail_edge", 64'(first_hit), 64'd72);
    chk("t3_offset", 64'(offset), 64'd3);
    chk("t3_locked_busy", 64'({locked, busy}), 64'h0);

    // Stream that never matches: each offset costs settle + one compare.
    din = 48'h0;
    pulse_train();
    wait_flag(1'b1, 74, first_hit);
    chk("nm_fail_edge", 64'(first_hit), 64'd12);
    chk("nm_offset", 64'(offset), 64'd3);
    chk("nm_locked", 64'(locked), 64'h0);

    // Restart mid-COUNT at offset 1 (nine matches) with the stream now aligned at 0.
    din = wrot[1];
    pulse_train();
    step(14);
    chk("t5_offset1", 64'(offset), 64'd1);
    chk("t5_busy", 64'(busy), 64'h1);
    din = P;
    pulse_train();
    chk("t5_restart_offset", 64'(offset), 64'd0);
    step(17);
    chk("t5_not_yet", 64'(locked), 64'h0);
    step(1);
    chk("t5_locked", 64'({locked, busy}), 64'b10);
    chk("t5_final_offset", 64'(offset), 64'd0);

    // train_i on the would-be lock edge restarts the search instead.
    pulse_train();
    step(17);
    pulse_train();
    chk("race_locked", 64'(locked), 64'h0);
    chk("race_busy", 64'(busy), 64'h1);
    step(17);
    chk("race_not_yet", 64'(locked), 64'h0);
    step(1);
    chk("race_relock", 64'(locked), 64'h1);

    // Word delay 5: single marker shows up 7 cycles after it enters.
    delay = 3'd5;
    step(10);
    din = MARKER;
    step(1);
    din = P;
    step(5);
    chk("dly_k6", 64'(dout), 64'(P));
    step(1);
    chk("dly_k7", 64'(dout), 64'(MARKER));
    step(1);
    chk("dly_k8", 64'(dout), 64'(P));

    // Mismatch counter: retrain clears it, then three isolated bad words.
    pulse_train();
    chk("err_cleared", 64'(err_count), 64'h0);
    step(18);
    chk("err_relock", 64'(locked), 64'h1);
    for (int i = 0; i < 3; i++) begin
      din = 48'h0;
      step(1);
      din = P;
      step(2);
    end
    step(3);
    chk("err_count", 64'(err_count), 64'(EXP_ERR));
    chk("err_still_locked", 64'(locked), 64'h1);

    // Asynchronous reset in the middle of a search.
    din = wrot[3];
    pulse_train();
    step(5);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 64'(busy), 64'h0);
    chk("arst_dout", 64'(dout), 64'h0);
    chk("arst_offset", 64'(offset), 64'h0);
    step(2);
    rst_n = 1'b1;
    step(2);
    chk("arst_idle", 64'({busy, locked, fail}), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
